// File: rtl/mmss_timer_pkg.sv
// Shared types and seven-segment helpers for the MM:SS timer.
package mmss_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef struct packed {
        logic [3:0] mt;
        logic [3:0] mu;
        logic [3:0] st;
        logic [3:0] su;
    } digits_t;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
        case (d)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

    function automatic logic [6:0] min_val(input logic [3:0] tens, input logic [3:0] units);
        return 7'(tens) * 7'd10 + 7'(units);
    endfunction

endpackage

// File: rtl/mmss_timer_if.sv
// Control and display bundle of the MM:SS timer.
interface mmss_timer_if;
    logic        run;
    logic        up_dn;
    logic        load;
    logic [15:0] load_bcd;
    logic [7:0]  hex3;
    logic [7:0]  hex2;
    logic [7:0]  hex1;
    logic [7:0]  hex0;
    logic        wrap;
    logic        done;
    logic        load_err;

    modport master (
        output run, up_dn, load, load_bcd,
        input  hex3, hex2, hex1, hex0, wrap, done, load_err
    );

    modport slave (
        input  run, up_dn, load, load_bcd,
        output hex3, hex2, hex1, hex0, wrap, done, load_err
    );
endinterface

// File: rtl/mmss_timer_prescaler.sv
// Tick-enable prescaler: counts 0..DIV-1 while enabled, tick on the last count.
module mmss_prescaler #(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick,
    output logic first_half
);
    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [W-1:0] cnt;

    assign tick       = en && (cnt == W'(DIV - 1));
    assign first_half = cnt < W'(DIV / 2);

    always_ff @(posedge clk) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= tick ? '0 : cnt + 1'b1;
    end
endmodule

// File: rtl/mmss_timer.sv
// MM:SS up/down timer with BCD load, terminal pulses and registered 7-seg outputs.
module mmss_timer
    import mmss_pkg::*;
#(
    parameter int CLK_HZ   = 50000000,
    parameter int TICK_HZ  = 1,
    parameter int MAX_MIN  = 59,
    parameter int INIT_MIN = 58,
    parameter int INIT_SEC = 57
) (
    input logic        clk,
    input logic        rst_n,
    mmss_timer_if.slave bus
);
    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam digits_t INIT_D = '{
        mt: 4'(INIT_MIN / 10), mu: 4'(INIT_MIN % 10),
        st: 4'(INIT_SEC / 10), su: 4'(INIT_SEC % 10)
    };

    digits_t dig, nxt, ld, disp;
    logic    tick, first_half, ld_ok;
    logic    wrap_n, done_n, err_n;
    logic    wrap_q, done_q, err_q;
    logic [7:0] hex3_q, hex2_q, hex1_q, hex0_q;

    // Any load request, good or bad, stalls the prescaler for that cycle.
    mmss_prescaler #(.DIV(DIV)) u_presc (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (bus.run && !bus.load),
        .clr        (bus.load && ld_ok),
        .tick       (tick),
        .first_half (first_half)
    );

    assign ld    = digits_t'(bus.load_bcd);
    assign ld_ok = (ld.mt <= 4'd9) && (ld.mu <= 4'd9) && (ld.st <= 4'd5) && (ld.su <= 4'd9)
                && (min_val(ld.mt, ld.mu) <= 7'(MAX_MIN));

    always_comb begin
        nxt    = dig;
        wrap_n = 1'b0;
        done_n = 1'b0;
        err_n  = 1'b0;
        if (bus.load) begin
            if (ld_ok) nxt = ld;
            else       err_n = 1'b1;
        end else if (tick) begin
            if (bus.up_dn) begin
                if (min_val(dig.mt, dig.mu) == 7'(MAX_MIN) && dig.st == 4'd5 && dig.su == 4'd9) begin
                    nxt    = '0;
                    wrap_n = 1'b1;
                end else if (dig.su != 4'd9) begin
                    nxt.su = dig.su + 4'd1;
                end else begin
                    nxt.su = 4'd0;
                    if (dig.st != 4'd5) nxt.st = dig.st + 4'd1;
                    else begin
                        nxt.st = 4'd0;
                        if (dig.mu != 4'd9) nxt.mu = dig.mu + 4'd1;
                        else begin
                            nxt.mu = 4'd0;
                            nxt.mt = dig.mt + 4'd1;
                        end
                    end
                end
            end else if (dig != '0) begin
                if (dig.su != 4'd0) nxt.su = dig.su - 4'd1;
                else begin
                    nxt.su = 4'd9;
                    if (dig.st != 4'd0) nxt.st = dig.st - 4'd1;
                    else begin
                        nxt.st = 4'd5;
                        if (dig.mu != 4'd0) nxt.mu = dig.mu - 4'd1;
                        else begin
                            nxt.mu = 4'd9;
                            nxt.mt = dig.mt - 4'd1;
                        end
                    end
                end
                done_n = (nxt == '0);
            end
        end
    end

    // Displays decode the value the digit registers are about to hold.
    assign disp = rst_n ? nxt : INIT_D;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dig    <= INIT_D;
            wrap_q <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            dig    <= nxt;
            wrap_q <= wrap_n;
            done_q <= done_n;
            err_q  <= err_n;
        end
    end

    always_ff @(posedge clk) begin
        hex3_q <= {1'b1, bcd_to_seg(disp.mt)};
        hex2_q <= {(rst_n && bus.run) ? ~first_half : 1'b0, bcd_to_seg(disp.mu)};
        hex1_q <= {1'b1, bcd_to_seg(disp.st)};
        hex0_q <= {1'b1, bcd_to_seg(disp.su)};
    end

    assign bus.hex3     = hex3_q;
    assign bus.hex2     = hex2_q;
    assign bus.hex1     = hex1_q;
    assign bus.hex0     = hex0_q;
    assign bus.wrap     = wrap_q;
    assign bus.done     = done_q;
    assign bus.load_err = err_q;
endmodule
